imem_boot_loader: RTL

Byte-serial boot loader that sits directly upstream of the MIPS_R2000 core and its instruction memory. It receives a framed program image one byte at a time and assembles big-endian 32-bit words. Each word is written into instruction memory at consecutive word addresses, and the core is held in reset until the image has been loaded and its checksum verified. It replaces `$readmemh` preloading on silicon/FPGA targets.

---
 rtl/imem_boot_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Byte-serial boot loader: receives a framed program image, assembles big-endian
// 32-bit words, writes them to instruction memory and holds the core in reset
// until the image checksum has been verified.
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  InValid,
  input  logic [7:0]            InData,
  output logic                  InReady,
  input  logic                  Rearm,
  output logic                  IMemWE,
  output logic [ADDR_WIDTH-1:0] IMemAddr,
  output logic [31:0]           IMemWData,
  output logic                  CpuRst,
  output logic                  Done,
  output logic                  Err
);

  // Counters are one bit wider than the 16-bit length so a full 2^ADDR_WIDTH
  // image can complete without the word index wrapping.
  localparam int unsigned   CntW     = 17;
  localparam logic [CntW-1:0] MaxWords = CntW'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StCsum,
    StDone,
    StError
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [CntW-1:0]       word_cnt_q, word_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           asm_q, asm_d;
  logic [7:0]            csum_q, csum_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;

  logic                  in_ready;
  logic                  xfer;
  logic [CntW-1:0]       len_full;
  logic [CntW-1:0]       word_next;
  logic [31:0]           new_word;

  assign in_ready  = (state_q != StDone) && (state_q != StError);
  assign xfer      = InValid && in_ready;
  assign len_full  = {1'b0, len_q[15:8], InData};
  assign word_next = word_cnt_q + CntW'(1);
  assign new_word  = {asm_q, InData};

  // Next-state, counter and write-port logic.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      StIdle: begin
        if (xfer && (InData == HDR_BYTE)) begin
          state_d    = StLenHi;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
          csum_d     = '0;
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_d[15:8] = InData;
          state_d     = StLenLo;
        end
      end
      StLenLo: begin
        if (xfer) begin
          len_d[7:0] = InData;
          if (len_full > MaxWords) begin
            state_d = StError;
          end else if (len_full == '0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          csum_d = csum_q ^ InData;
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
            imem_wdata_d = new_word;
            byte_cnt_d   = '0;
            asm_d        = '0;
            word_cnt_d   = word_next;
            if (word_next == {1'b0, len_q}) begin
              state_d = StCsum;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            asm_d      = new_word[23:0];
          end
        end
      end
      StCsum: begin
        if (xfer) begin
          state_d = (InData == csum_q) ? StDone : StError;
        end
      end
      StDone, StError: begin
        if (Rearm) begin
          state_d    = StIdle;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
          csum_d     = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      csum_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      csum_q       <= csum_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    InReady   = in_ready;
    CpuRst    = (state_q != StDone);
    Done      = (state_q == StDone);
    Err       = (state_q == StError);
    IMemWE    = imem_we_q;
    IMemAddr  = imem_addr_q;
    IMemWData = imem_wdata_q;
  end

endmodule
